// File: rtl/mem_stage_unit.sv
// Memory-access stage: data-memory request/ack handshake, store lane alignment,
// load extension and the MEM/WB register, with upstream stall and bubble insertion.
module mem_stage_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] alu_input2_in,
  input  logic [2:0]  func3_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemReg_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        branchAlu_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        misalign_err,
  output logic [63:0] wb_data_out,
  output logic [4:0]  wb_rd_out,
  output logic        wb_RegWrite_out,
  output logic        pc_src_out
);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_mem_op, w_misalign, w_regwrite, w_pc_src;
  logic        w_issue, w_complete, w_wb_update, w_misalign_pulse;
  logic [2:0]  w_off;
  logic [63:0] w_wb_data;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    if (f3 == 3'b111) return 1'b1;
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] f3,
                                              input logic [2:0] off);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{sh[7]}},  sh[7:0]};
      3'b001:  return {{48{sh[15]}}, sh[15:0]};
      3'b010:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'd0, sh[7:0]};
      3'b101:  return {48'd0, sh[15:0]};
      3'b110:  return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [7:0] store_strobe(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  assign w_off      = alu_result_in[2:0];
  assign w_mem_op   = MemRead_in | MemWrite_in;
  assign w_misalign = is_misaligned(func3_in, w_off);
  assign w_regwrite = RegWrite_in & (rd_in != 5'd0);
  assign w_pc_src   = (Branch_in & branchAlu_in) | Jump_in;
  assign w_wb_data  = Jump_in   ? pc_in + 64'd4 :
                      MemReg_in ? load_extend(dmem_rdata, func3_in, w_off) : alu_result_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    stall            = 1'b0;
    w_issue          = 1'b0;
    w_complete       = 1'b0;
    w_wb_update      = 1'b0;
    w_misalign_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_wb_update = 1'b1;
        end else if (w_misalign) begin
          w_misalign_pulse = 1'b1;
        end else begin
          stall       = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          w_wb_update = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request registers and MEM/WB register; anything that is neither a write-back
  // nor a misaligned access writes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 64'd0;
      dmem_wdata      <= 64'd0;
      dmem_wstrb      <= 8'd0;
      misalign_err    <= 1'b0;
      wb_data_out     <= 64'd0;
      wb_rd_out       <= 5'd0;
      wb_RegWrite_out <= 1'b0;
      pc_src_out      <= 1'b0;
    end else begin
      misalign_err <= w_misalign_pulse;
      if (w_issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_in;
        dmem_addr  <= {alu_result_in[63:3], 3'b000};
        dmem_wdata <= MemWrite_in ? (alu_input2_in << {w_off, 3'b000}) : 64'd0;
        dmem_wstrb <= MemWrite_in ? store_strobe(func3_in, w_off) : 8'd0;
      end else if (w_complete) begin
        dmem_req <= 1'b0;
      end
      if (w_wb_update) begin
        wb_data_out     <= w_wb_data;
        wb_rd_out       <= rd_in;
        wb_RegWrite_out <= w_regwrite;
        pc_src_out      <= w_pc_src;
      end else if (w_misalign_pulse) begin
        wb_data_out     <= w_wb_data;
        wb_rd_out       <= rd_in;
        wb_RegWrite_out <= 1'b0;
        pc_src_out      <= w_pc_src;
      end else begin
        wb_RegWrite_out <= 1'b0;
        pc_src_out      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed vector bench for mem_stage_unit: table of single instructions with a
// scripted ack delay, plus hand sequences for reset-in-WAIT and ack-in-IDLE.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in, alu_result_in, alu_input2_in, dmem_rdata;
  logic [2:0]  func3_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemReg_in, Branch_in, Jump_in, branchAlu_in;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, misalign_err, wb_RegWrite_out, pc_src_out;
  logic [63:0] dmem_addr, dmem_wdata, wb_data_out;
  logic [7:0]  dmem_wstrb;
  logic [4:0]  wb_rd_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .alu_input2_in(alu_input2_in), .func3_in(func3_in), .rd_in(rd_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemReg_in(MemReg_in), .Branch_in(Branch_in), .Jump_in(Jump_in), .branchAlu_in(branchAlu_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .misalign_err(misalign_err), .wb_data_out(wb_data_out), .wb_rd_out(wb_rd_out),
    .wb_RegWrite_out(wb_RegWrite_out), .pc_src_out(pc_src_out)
  );

  typedef struct {
    logic [63:0] pc, alu, in2, rdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw, mr, mw, mreg, br, jmp, bralu;
    int          delay;
    logic        chk_data;
    logic [63:0] e_wb, e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    logic        e_rw, e_pcsrc, e_mis, e_we;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t blank();
    vec_t v;
    v.pc = 0; v.alu = 0; v.in2 = 0; v.rdata = 0; v.f3 = 0; v.rd = 0;
    v.rw = 0; v.mr = 0; v.mw = 0; v.mreg = 0; v.br = 0; v.jmp = 0; v.bralu = 0;
    v.delay = 0; v.chk_data = 1; v.e_wb = 0; v.e_addr = 0; v.e_wdata = 0; v.e_wstrb = 0;
    v.e_rw = 0; v.e_pcsrc = 0; v.e_mis = 0; v.e_we = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc_in = v.pc; alu_result_in = v.alu; alu_input2_in = v.in2; dmem_rdata = v.rdata;
    func3_in = v.f3; rd_in = v.rd; RegWrite_in = v.rw; MemRead_in = v.mr; MemWrite_in = v.mw;
    MemReg_in = v.mreg; Branch_in = v.br; Jump_in = v.jmp; branchAlu_in = v.bralu;
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge after the final edge.
  task automatic run_vec(input int idx, input vec_t v);
    int n, waits, stalls;
    bit done;
    n = 0; waits = 0; stalls = 0; done = 0;
    drive(v);
    while (!done && n < 20) begin
      if (dmem_req) waits++;
      dmem_ack = dmem_req && (waits == v.delay);
      #1;
      if (stall) stalls++;
      if (dmem_req) begin
        chk($sformatf("v%0d_addr", idx), dmem_addr, v.e_addr);
        chk($sformatf("v%0d_we", idx), dmem_we, v.e_we);
        chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.e_wdata);
        chk($sformatf("v%0d_wstrb", idx), dmem_wstrb, v.e_wstrb);
        chk($sformatf("v%0d_bubble_rw", idx), wb_RegWrite_out, 0);
      end
      if (!stall) done = 1;
      @(negedge clk);
      n++;
    end
    dmem_ack = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL v%0d_timeout actual=%0d cycles required=%0d", idx, n, 1 + v.delay);
    end
    chk($sformatf("v%0d_cycles", idx), n, (v.delay == 0) ? 1 : 1 + v.delay);
    chk($sformatf("v%0d_stalls", idx), stalls, v.delay);
    chk($sformatf("v%0d_reqcyc", idx), waits, v.delay);
    chk($sformatf("v%0d_req_low", idx), dmem_req, 0);
    if (v.chk_data) chk($sformatf("v%0d_wbdata", idx), wb_data_out, v.e_wb);
    chk($sformatf("v%0d_wbrd", idx), wb_rd_out, v.rd);
    chk($sformatf("v%0d_wbrw", idx), wb_RegWrite_out, v.e_rw);
    chk($sformatf("v%0d_pcsrc", idx), pc_src_out, v.e_pcsrc);
    chk($sformatf("v%0d_mis", idx), misalign_err, v.e_mis);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, dmem_req, 0);       chk({nm, "_we"}, dmem_we, 0);
    chk({nm, "_addr"}, dmem_addr, 0);     chk({nm, "_wdata"}, dmem_wdata, 0);
    chk({nm, "_wstrb"}, dmem_wstrb, 0);   chk({nm, "_mis"}, misalign_err, 0);
    chk({nm, "_wbdata"}, wb_data_out, 0); chk({nm, "_wbrd"}, wb_rd_out, 0);
    chk({nm, "_wbrw"}, wb_RegWrite_out, 0); chk({nm, "_pcsrc"}, pc_src_out, 0);
  endtask

  initial begin
    vec_t v;
    // 0: ADD
    v = blank(); v.alu = 64'h1234; v.rd = 5; v.rw = 1; v.e_wb = 64'h1234; v.e_rw = 1; vq.push_back(v);
    // 1: lb 0x1003, ack first WAIT cycle
    v = blank(); v.alu = 64'h1003; v.f3 = 3'b000; v.rd = 6; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.rdata = 64'h0000_0000_8000_0000; v.delay = 1; v.e_addr = 64'h1000;
    v.e_wb = 64'hFFFF_FFFF_FFFF_FF80; v.e_rw = 1; vq.push_back(v);
    // 2: lhu 0x2006
    v = blank(); v.alu = 64'h2006; v.f3 = 3'b101; v.rd = 7; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.rdata = 64'hBEEF_0000_0000_0000; v.delay = 2; v.e_addr = 64'h2000;
    v.e_wb = 64'h0000_0000_0000_BEEF; v.e_rw = 1; vq.push_back(v);
    // 3: sw 0xDEADBEEF at 0x14, ack after 3 WAIT cycles
    v = blank(); v.alu = 64'h14; v.in2 = 64'hDEADBEEF; v.f3 = 3'b010; v.mw = 1; v.delay = 3;
    v.e_addr = 64'h10; v.e_we = 1; v.e_wdata = 64'hDEADBEEF_0000_0000; v.e_wstrb = 8'hF0;
    v.e_wb = 64'h14; vq.push_back(v);
    // 4: ld misaligned at 0x3004
    v = blank(); v.alu = 64'h3004; v.f3 = 3'b011; v.rd = 8; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.chk_data = 0; v.e_mis = 1; vq.push_back(v);
    // 5: jal at 0x400, rd=1
    v = blank(); v.pc = 64'h400; v.alu = 64'h999; v.rd = 1; v.rw = 1; v.jmp = 1;
    v.e_wb = 64'h404; v.e_rw = 1; v.e_pcsrc = 1; vq.push_back(v);
    // 6: beq not taken
    v = blank(); v.alu = 64'h1; v.br = 1; v.bralu = 0; v.e_wb = 64'h1; vq.push_back(v);
    // 7: beq taken
    v = blank(); v.alu = 64'h0; v.br = 1; v.bralu = 1; v.e_pcsrc = 1; vq.push_back(v);
    // 8: lw 0x2004, sign-extended
    v = blank(); v.alu = 64'h2004; v.f3 = 3'b010; v.rd = 10; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.rdata = 64'h8765_4321_0000_0000; v.delay = 1; v.e_addr = 64'h2000;
    v.e_wb = 64'hFFFF_FFFF_8765_4321; v.e_rw = 1; vq.push_back(v);
    // 9: sd at 0x38
    v = blank(); v.alu = 64'h38; v.in2 = 64'h0123_4567_89AB_CDEF; v.f3 = 3'b011; v.mw = 1;
    v.delay = 1; v.e_addr = 64'h38; v.e_we = 1; v.e_wdata = 64'h0123_4567_89AB_CDEF;
    v.e_wstrb = 8'hFF; v.e_wb = 64'h38; vq.push_back(v);
    // 10: sb at 0x47
    v = blank(); v.alu = 64'h47; v.in2 = 64'h1122_3344_5566_77AB; v.f3 = 3'b000; v.mw = 1;
    v.delay = 2; v.e_addr = 64'h40; v.e_we = 1; v.e_wdata = 64'hAB00_0000_0000_0000;
    v.e_wstrb = 8'h80; v.e_wb = 64'h47; vq.push_back(v);
    // 11: write to x0 suppressed
    v = blank(); v.alu = 64'h77; v.rd = 0; v.rw = 1; v.e_wb = 64'h77; vq.push_back(v);
    // 12: func3=111 load at aligned address is misaligned
    v = blank(); v.alu = 64'h50; v.f3 = 3'b111; v.rd = 4; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.chk_data = 0; v.e_mis = 1; vq.push_back(v);
    // 13: jal with pc+4 wrapping
    v = blank(); v.pc = 64'hFFFF_FFFF_FFFF_FFFC; v.rd = 2; v.rw = 1; v.jmp = 1;
    v.e_wb = 64'h0; v.e_rw = 1; v.e_pcsrc = 1; vq.push_back(v);
    // 14: lbu 0x1003
    v = blank(); v.alu = 64'h1003; v.f3 = 3'b100; v.rd = 11; v.rw = 1; v.mr = 1; v.mreg = 1;
    v.rdata = 64'h0000_0000_8000_0000; v.delay = 1; v.e_addr = 64'h1000;
    v.e_wb = 64'h80; v.e_rw = 1; vq.push_back(v);

    reset = 1'b1; dmem_ack = 1'b0; drive(blank());
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (vq[i]) run_vec(i, vq[i]);

    // Reset in the 2nd WAIT cycle of a load, with a simultaneous ack.
    v = blank(); v.alu = 64'h1008; v.f3 = 3'b000; v.rd = 9; v.rw = 1; v.mr = 1; v.mreg = 1;
    drive(v);
    #1 chk("rw_issue_stall", stall, 1);
    @(negedge clk);
    chk("rw_req_wait1", dmem_req, 1);
    chk("rw_addr_wait1", dmem_addr, 64'h1008);
    @(negedge clk);
    chk("rw_req_wait2", dmem_req, 1);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h7F;
    @(negedge clk);
    chk_all_zero("rstwait");
    reset = 1'b0; dmem_ack = 1'b0; drive(blank());
    #1 chk("rstwait_idle_stall", stall, 0);

    // Ack while idle is ignored; the ALU result still writes back.
    v = blank(); v.alu = 64'h55; v.rd = 3; v.rw = 1;
    drive(v); dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idleack_req", dmem_req, 0);
    chk("idleack_wbdata", wb_data_out, 64'h55);
    chk("idleack_wbrw", wb_RegWrite_out, 1);
    #1 chk("idleack_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory-access stage of the pipelined RV64 core: consumes the EX/MEM pipeline register outputs, runs the data-memory request/acknowledge handshake, aligns store data and extends load data, and registers the MEM/WB values. It stalls upstream while an access is outstanding. It inserts a write-back bubble for stalled cycles and misaligned accesses.

## Interface
- No parameters; data width fixed at 64 bits, data bus 8 bytes wide.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_in, alu_result_in, alu_input2_in  in  64 each  EX/MEM: PC, effective address / ALU result, store data
- func3_in  in  3  load/store size and signedness
- rd_in  in  5  destination register
- RegWrite_in, MemRead_in, MemWrite_in, MemReg_in, Branch_in, Jump_in, branchAlu_in  in  1 each  EX/MEM control
- dmem_req  out  1  access request, held until acknowledged
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  64  doubleword-aligned address (addr[2:0] = 0)
- dmem_wdata  out  64  store data shifted to its byte lanes
- dmem_wstrb  out  8  byte-lane write strobes (0 for loads)
- dmem_rdata  in  64  load data, valid in the cycle dmem_ack = 1
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  combinational; upstream must hold the EX/MEM register while it is 1
- misalign_err  out  1  registered one-cycle pulse for a misaligned access
- wb_data_out  out  64  registered write-back value
- wb_rd_out  out  5  registered destination register
- wb_RegWrite_out  out  1  registered write enable
- pc_src_out  out  1  registered: (Branch_in & branchAlu_in) | Jump_in

## Operation
- mem_op = MemRead_in | MemWrite_in. Address offset is off = alu_result_in[2:0].
- Alignment check:
  - Size by func3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - The access is misaligned when off is not a multiple of the size.
  - func3 = 111 is also treated as misaligned.
- Stores (func3 000/001/010/011 = sb/sh/sw/sd):
  - dmem_wdata = alu_input2_in << (8·off).
  - dmem_wstrb = (0x01/0x03/0x0F/0xFF) << off.
- Loads (func3 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu):
  - Extract dmem_rdata >> (8·off) and truncate to the access size.
  - func3[2] = 0 sign-extends to 64 bits; func3[2] = 1 zero-extends.
- Write-back value: Jump_in selects pc_in + 4 (mod 2^64); otherwise MemReg_in selects the load data; otherwise alu_result_in.
- wb_RegWrite_out = RegWrite_in & (rd_in != 0), forced to 0 for bubbles and misaligned accesses.
- State machine (states IDLE, WAIT):
  - IDLE, no mem_op: the MEM/WB registers update at the edge; stall = 0.
  - IDLE, misaligned mem_op:
    - No request is issued.
    - At the edge: misalign_err = 1, wb_RegWrite_out = 0, pc_src_out updates; stall = 0.
  - IDLE, aligned mem_op:
    - stall = 1.
    - At the edge: latch dmem_addr (alu_result_in with bits [2:0] cleared), dmem_we, dmem_wdata, dmem_wstrb; set dmem_req = 1; write a bubble into MEM/WB (wb_RegWrite_out = 0, pc_src_out = 0); go to WAIT.
  - WAIT, dmem_ack = 0: stall = 1; request outputs held stable; the bubble is repeated.
  - WAIT, dmem_ack = 1:
    - stall = 0.
    - At the edge: MEM/WB registers update with the final values; dmem_req = 0; go to IDLE.
- dmem_ack while in IDLE is ignored.
- Reset:
  - The FSM goes to IDLE.
  - All outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, misalign_err, wb_data_out, wb_rd_out, wb_RegWrite_out, pc_src_out.
  - Reset during WAIT abandons the request: dmem_req = 0 the next cycle, and no write-back occurs.
  - reset takes priority over a simultaneous dmem_ack.

## Timing
- Non-memory instruction: 1 cycle. Outputs are valid the cycle after the instruction is presented.
- Memory access: 1 + N cycles, where N ≥ 1 is the number of WAIT cycles up to and including the ack.
  - The minimum is 2 cycles, when the ack arrives in the first WAIT cycle.
  - stall is high for exactly N cycles... more precisely, for the IDLE cycle plus every WAIT cycle without ack.
- dmem_req rises the edge after the aligned mem_op is seen, and falls the edge after the ack.
- Back-to-back memory ops: the second op is seen in the cycle after the ack, so dmem_req is low for at least 1 cycle between them.
- misalign_err is high for exactly 1 cycle per misaligned instruction.

## Test plan
- ADD result 0x1234, rd = 5, RegWrite = 1 -> next cycle: wb_data_out = 0x1234, wb_rd_out = 5, wb_RegWrite_out = 1; stall never rises.
- lb at addr 0x1003 with ack on the first WAIT cycle; dmem_rdata = 0x0000_0000_8000_0000 -> dmem_addr = 0x1000; wb_data_out = 0xFFFF_FFFF_FFFF_FF80; total 2 cycles with stall = 1 for 1 cycle.
- lhu at addr 0x2006, dmem_rdata = 0xBEEF_0000_0000_0000 -> wb_data_out = 0x0000_0000_0000_BEEF.
- sw of 0xDEADBEEF at addr 0x10 + 4 with ack delayed 3 WAIT cycles:
  - dmem_we = 1, dmem_wstrb = 0xF0, dmem_wdata = 0xDEADBEEF_00000000.
  - dmem_req stays stable and high for 3 cycles; stall = 1 for 3 cycles.
  - wb_RegWrite_out = 0 throughout.
- ld at addr 0x3004 -> misalign_err pulses once; dmem_req stays 0; wb_RegWrite_out = 0; stall = 0.
- reset asserted in the 2nd WAIT cycle of a load, then ack arrives in the reset cycle -> the next cycle all outputs are 0, the FSM is in IDLE, and no write-back occurs.
- jal at pc 0x400 with rd = 1 -> wb_data_out = 0x404, pc_src_out = 1. beq with branchAlu = 0 -> pc_src_out = 0.
